// File: rtl/div_pkg.sv
// Shared definitions for the divider front-end and the unsigned divider core.
package div_pkg;

    localparam int WIDTH        = 32;
    localparam int CORE_TIMEOUT = 80;

    localparam logic [WIDTH-1:0] INT_MIN  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PREP  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_FIX   = 3'd4,
        ST_OUT   = 3'd5
    } state_t;

endpackage

// File: rtl/div_sign_ctrl_cond_neg.sv
// Conditional two's-complement negation: y = neg ? -x : x (mod 2^WIDTH).
module cond_neg #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] x,
    input  logic             neg,
    output logic [WIDTH-1:0] y
);

    assign y = neg ? (~x + {{(WIDTH-1){1'b0}}, 1'b1}) : x;

endmodule

// File: rtl/div_sign_ctrl.sv
// Signed/unsigned divide front-end: screens div-by-zero and signed overflow,
// feeds operand magnitudes to the unsigned core and restores result signs.
module div_sign_ctrl
    import div_pkg::*;
#(
    parameter int WIDTH        = div_pkg::WIDTH,
    parameter int CORE_TIMEOUT = div_pkg::CORE_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_signed,
    input  logic [WIDTH-1:0] in_dividend,
    input  logic [WIDTH-1:0] in_divisor,
    output logic             core_start,
    output logic [WIDTH-1:0] core_dividend,
    output logic [WIDTH-1:0] core_divisor,
    input  logic             core_done,
    input  logic [WIDTH-1:0] core_quotient,
    input  logic [WIDTH-1:0] core_remainder,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_quotient,
    output logic [WIDTH-1:0] out_remainder,
    output logic             out_div0,
    output logic             out_ovf,
    output logic             out_timeout
);

    localparam int CNT_W = $clog2(CORE_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CORE_TIMEOUT - 1);
    localparam logic [WIDTH-1:0] MIN_V    = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONES_V   = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO_V   = {WIDTH{1'b0}};

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic               sgn_q, sgn_d;
    logic               neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0]   uq_q, uq_d, ur_q, ur_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               core_start_q, core_start_d;
    logic [WIDTH-1:0]   core_dvd_q, core_dvd_d, core_dvs_q, core_dvs_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   out_quo_q, out_quo_d, out_rem_q, out_rem_d;
    logic               div0_q, div0_d, ovf_q, ovf_d, tmo_q, tmo_d;

    logic [WIDTH-1:0]   mag_a_s, mag_b_s, fix_q_s, fix_r_s;

    cond_neg #(.WIDTH(WIDTH)) u_mag_a (.x(a_q),  .neg(sgn_q & a_q[WIDTH-1]), .y(mag_a_s));
    cond_neg #(.WIDTH(WIDTH)) u_mag_b (.x(b_q),  .neg(sgn_q & b_q[WIDTH-1]), .y(mag_b_s));
    cond_neg #(.WIDTH(WIDTH)) u_fix_q (.x(uq_q), .neg(neg_quo_q),           .y(fix_q_s));
    cond_neg #(.WIDTH(WIDTH)) u_fix_r (.x(ur_q), .neg(neg_rem_q),           .y(fix_r_s));

    assign in_ready      = rst && (state_q == ST_IDLE);
    assign core_start    = core_start_q;
    assign core_dividend = core_dvd_q;
    assign core_divisor  = core_dvs_q;
    assign out_valid     = out_valid_q;
    assign out_quotient  = out_quo_q;
    assign out_remainder = out_rem_q;
    assign out_div0      = div0_q;
    assign out_ovf       = ovf_q;
    assign out_timeout   = tmo_q;

    // Next-state and datapath update for the request sequencer.
    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        sgn_d        = sgn_q;
        neg_quo_d    = neg_quo_q;
        neg_rem_d    = neg_rem_q;
        uq_d         = uq_q;
        ur_d         = ur_q;
        cnt_d        = cnt_q;
        core_start_d = 1'b0;
        core_dvd_d   = core_dvd_q;
        core_dvs_d   = core_dvs_q;
        out_valid_d  = out_valid_q;
        out_quo_d    = out_quo_q;
        out_rem_d    = out_rem_q;
        div0_d       = div0_q;
        ovf_d        = ovf_q;
        tmo_d        = tmo_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d       = in_dividend;
                    b_d       = in_divisor;
                    sgn_d     = in_signed;
                    neg_quo_d = in_signed & (in_dividend[WIDTH-1] ^ in_divisor[WIDTH-1]);
                    neg_rem_d = in_signed & in_dividend[WIDTH-1];
                    state_d   = ST_PREP;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_PREP: begin
                if (b_q == ZERO_V) begin
                    out_quo_d   = ONES_V;
                    out_rem_d   = a_q;
                    div0_d      = 1'b1;
                    out_valid_d = 1'b1;
                    state_d     = ST_OUT;
                end else if (sgn_q && (a_q == MIN_V) && (b_q == ONES_V)) begin
                    out_quo_d   = MIN_V;
                    out_rem_d   = ZERO_V;
                    ovf_d       = 1'b1;
                    out_valid_d = 1'b1;
                    state_d     = ST_OUT;
                end else begin
                    core_dvd_d   = mag_a_s;
                    core_dvs_d   = mag_b_s;
                    core_start_d = 1'b1;
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = {CNT_W{1'b0}};
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A core answer on the last budget cycle still wins over the abort.
                if (core_done) begin
                    uq_d    = core_quotient;
                    ur_d    = core_remainder;
                    state_d = ST_FIX;
                end else if (cnt_q == CNT_LAST) begin
                    out_quo_d   = ONES_V;
                    out_rem_d   = a_q;
                    tmo_d       = 1'b1;
                    out_valid_d = 1'b1;
                    state_d     = ST_OUT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_FIX: begin
                out_quo_d   = fix_q_s;
                out_rem_d   = fix_r_s;
                out_valid_d = 1'b1;
                state_d     = ST_OUT;
            end
            ST_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    div0_d      = 1'b0;
                    ovf_d       = 1'b0;
                    tmo_d       = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d     = ST_OUT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            a_q          <= {WIDTH{1'b0}};
            b_q          <= {WIDTH{1'b0}};
            sgn_q        <= 1'b0;
            neg_quo_q    <= 1'b0;
            neg_rem_q    <= 1'b0;
            uq_q         <= {WIDTH{1'b0}};
            ur_q         <= {WIDTH{1'b0}};
            cnt_q        <= {CNT_W{1'b0}};
            core_start_q <= 1'b0;
            core_dvd_q   <= {WIDTH{1'b0}};
            core_dvs_q   <= {WIDTH{1'b0}};
            out_valid_q  <= 1'b0;
            out_quo_q    <= {WIDTH{1'b0}};
            out_rem_q    <= {WIDTH{1'b0}};
            div0_q       <= 1'b0;
            ovf_q        <= 1'b0;
            tmo_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            sgn_q        <= sgn_d;
            neg_quo_q    <= neg_quo_d;
            neg_rem_q    <= neg_rem_d;
            uq_q         <= uq_d;
            ur_q         <= ur_d;
            cnt_q        <= cnt_d;
            core_start_q <= core_start_d;
            core_dvd_q   <= core_dvd_d;
            core_dvs_q   <= core_dvs_d;
            out_valid_q  <= out_valid_d;
            out_quo_q    <= out_quo_d;
            out_rem_q    <= out_rem_d;
            div0_q       <= div0_d;
            ovf_q        <= ovf_d;
            tmo_q        <= tmo_d;
        end
    end

endmodule

// File: tb/tb_div_sign_ctrl.sv
// Scoreboard bench for div_sign_ctrl with a fixed-latency divider core model.
module tb_div_sign_ctrl;

    localparam int W   = 32;
    localparam int TMO = 80;
    localparam int LAT = 34;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready, in_signed;
    logic [W-1:0]  in_dividend, in_divisor;
    logic          core_start, core_done;
    logic [W-1:0]  core_dividend, core_divisor, core_quotient, core_remainder;
    logic          out_valid, out_ready;
    logic [W-1:0]  out_quotient, out_remainder;
    logic          out_div0, out_ovf, out_timeout;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         div0;
        logic         ovf;
        logic         tmo;
        int           lat;
        int           acc;
    } exp_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
    } core_t;

    exp_t  sb[$];
    core_t cq[$];
    int    checks   = 0;
    int    errors   = 0;
    int    done_cnt = 0;
    int    cyc      = 0;
    int    rst_cnt  = 0;
    bit    bfm_en   = 1'b1;

    div_sign_ctrl #(.WIDTH(W), .CORE_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_signed(in_signed),
        .in_dividend(in_dividend), .in_divisor(in_divisor),
        .core_start(core_start), .core_dividend(core_dividend), .core_divisor(core_divisor),
        .core_done(core_done), .core_quotient(core_quotient), .core_remainder(core_remainder),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_quotient(out_quotient), .out_remainder(out_remainder),
        .out_div0(out_div0), .out_ovf(out_ovf), .out_timeout(out_timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pop the scoreboard when a result appears, then watch it stay stable.
    initial begin : monitor
        exp_t cur;
        bit   active;
        active = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                active = 1'b0;
            end else if (out_valid) begin
                chk("in_ready_during_out", 32'(in_ready), 32'd0);
                if (!active) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_out_valid", 32'(out_valid), 32'd0);
                    end else begin
                        cur    = sb.pop_front();
                        active = 1'b1;
                        chk("quotient",  out_quotient,      cur.q);
                        chk("remainder", out_remainder,     cur.r);
                        chk("div0",      32'(out_div0),     32'(cur.div0));
                        chk("ovf",       32'(out_ovf),      32'(cur.ovf));
                        chk("timeout",   32'(out_timeout),  32'(cur.tmo));
                        if (cur.lat >= 0) chk("latency", 32'(cyc - cur.acc), 32'(cur.lat));
                    end
                end else begin
                    chk("hold_quotient",  out_quotient,  cur.q);
                    chk("hold_remainder", out_remainder, cur.r);
                    chk("hold_flags", 32'({out_div0, out_ovf, out_timeout}),
                        32'({cur.div0, cur.ovf, cur.tmo}));
                end
                if (out_ready) begin
                    active = 1'b0;
                    done_cnt++;
                end
            end
        end
    end

    // Divider core model: checks operands on each start, answers after LAT cycles.
    initial begin : bfm
        core_t        ce;
        logic [W-1:0] a, b;
        int           rc;
        core_done      = 1'b0;
        core_quotient  = '0;
        core_remainder = '0;
        forever begin
            @(negedge clk);
            if (rst && core_start) begin
                rc = rst_cnt;
                if (cq.size() == 0) begin
                    chk("unexpected_core_start", 32'(core_start), 32'd0);
                end else begin
                    ce = cq.pop_front();
                    chk("core_dividend", core_dividend, ce.a);
                    chk("core_divisor",  core_divisor,  ce.b);
                end
                a = core_dividend;
                b = core_divisor;
                @(negedge clk);
                chk("core_start_pulse", 32'(core_start), 32'd0);
                repeat (LAT - 1) @(posedge clk);
                #1;
                if (bfm_en) begin
                    if (rc == rst_cnt) chk("core_operands_stable", core_dividend, a);
                    core_quotient  = (b != '0) ? a / b : '1;
                    core_remainder = (b != '0) ? a % b : a;
                    core_done      = 1'b1;
                    @(posedge clk);
                    #1 core_done = 1'b0;
                end
            end
        end
    end

    task automatic issue(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er,
                         input bit d0, input bit ov, input bit tm, input int lat,
                         input bit use_core, input logic [W-1:0] ca, input logic [W-1:0] cb,
                         input bit push_sb);
        int n;
        n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("accept_ready", 32'(in_ready), 32'd1);
        in_valid    = 1'b1;
        in_signed   = sgn;
        in_dividend = a;
        in_divisor  = b;
        if (push_sb)  sb.push_back('{eq, er, d0, ov, tm, lat, cyc});
        if (use_core) cq.push_back('{ca, cb});
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int target, n;
        target = done_cnt + 1;
        n = 0;
        while (done_cnt < target && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("txn_completed", 32'(done_cnt >= target), 32'd1);
    endtask

    initial begin : driver
        int n, seen;
        rst = 1'b0; in_valid = 1'b0; in_signed = 1'b0;
        in_dividend = '0; in_divisor = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready",      32'(in_ready),   32'd0);
        chk("rst_out_valid",     32'(out_valid),  32'd0);
        chk("rst_core_start",    32'(core_start), 32'd0);
        chk("rst_out_quotient",  out_quotient,    32'd0);
        chk("rst_out_remainder", out_remainder,   32'd0);
        chk("rst_core_dividend", core_dividend,   32'd0);
        chk("rst_core_divisor",  core_divisor,    32'd0);
        chk("rst_flags", 32'({out_div0, out_ovf, out_timeout}), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // sgn, a, b, q, r, div0, ovf, tmo, latency, core?, core a, core b, scoreboard?
        issue(1'b1, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, LAT + 4, 1'b1, 32'h7, 32'h2, 1'b1);
        wait_done();
        issue(1'b1, 32'h7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h1, 1'b0, 1'b0, 1'b0, LAT + 4, 1'b1, 32'h7, 32'h2, 1'b1);
        wait_done();
        issue(1'b0, 32'hFFFF_FFFF, 32'h2, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0, LAT + 4, 1'b1, 32'hFFFF_FFFF, 32'h2, 1'b1);
        wait_done();
        issue(1'b1, 32'h5, 32'h0, 32'hFFFF_FFFF, 32'h5, 1'b1, 1'b0, 1'b0, 2, 1'b0, 32'h0, 32'h0, 1'b1);
        wait_done();
        issue(1'b0, 32'h5, 32'h0, 32'hFFFF_FFFF, 32'h5, 1'b1, 1'b0, 1'b0, 2, 1'b0, 32'h0, 32'h0, 1'b1);
        wait_done();
        issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 1'b0, 1'b1, 1'b0, 2, 1'b0, 32'h0, 32'h0, 1'b1);
        wait_done();
        issue(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 1'b0, 1'b0, LAT + 4, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        wait_done();
        // -100 / -7: quotient 14, remainder -2
        issue(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hE, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, LAT + 4, 1'b1, 32'h64, 32'h7, 1'b1);
        wait_done();
        // INT_MIN / 1: magnitude of INT_MIN passes through as 0x8000_0000
        issue(1'b1, 32'h8000_0000, 32'h1, 32'h8000_0000, 32'h0, 1'b0, 1'b0, 1'b0, LAT + 4, 1'b1, 32'h8000_0000, 32'h1, 1'b1);
        wait_done();

        // Consumer back-pressure for 10 cycles, then back-to-back follow-up.
        out_ready = 1'b0;
        issue(1'b1, 32'h64, 32'h7, 32'hE, 32'h2, 1'b0, 1'b0, 1'b0, LAT + 4, 1'b1, 32'h64, 32'h7, 1'b1);
        n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("hold_out_valid_seen", 32'(out_valid), 32'd1);
        repeat (10) @(posedge clk);
        #1;
        chk("hold_still_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        wait_done();
        chk("ready_after_release", 32'(in_ready), 32'd1);
        issue(1'b0, 32'hA, 32'h3, 32'h3, 32'h1, 1'b0, 1'b0, 1'b0, LAT + 4, 1'b1, 32'hA, 32'h3, 1'b1);
        wait_done();

        // Reset while waiting on the core; the late core_done must be ignored.
        issue(1'b1, 32'hFFFF_FFF9, 32'h2, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 32'h7, 32'h2, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        rst_cnt++;
        #1;
        chk("rst_mid_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("rst_mid_core_dividend", core_dividend, 32'd0);
        chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        seen = 0;
        repeat (50) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        chk("late_done_ignored", 32'(seen), 32'd0);

        // Silent core: abort after the timeout budget.
        bfm_en = 1'b0;
        issue(1'b1, 32'hFFFF_FFFB, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b0, 1'b0, 1'b1, TMO + 3, 1'b1, 32'h5, 32'h2, 1'b1);
        wait_done();
        repeat (LAT) @(posedge clk);
        #1 bfm_en = 1'b1;

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        chk("core_queue_empty", 32'(cq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
